// File: rtl/serial_csla_add32.sv
// Byte-serial adder: one 8-bit carry-select (BEC) slice reused over SLICES cycles with a registered carry.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN (adds the sub port).

module csla_bec_slice8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [4:0] lo_c;
  logic [3:0] lo_s;
  logic [4:0] hi_c;
  logic [3:0] hi_s;
  logic [4:0] hi_raw;
  logic [4:0] hi_inc;
  logic [4:0] inc_chain;

  assign lo_c[0] = ci;
  assign hi_c[0] = 1'b0;

  // Low nibble ripples on the real carry; high nibble assumes carry 0 and is fixed up by the BEC.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rca
      assign lo_s[gi]   = x[gi] ^ y[gi] ^ lo_c[gi];
      assign lo_c[gi+1] = (x[gi] & y[gi]) | (lo_c[gi] & (x[gi] ^ y[gi]));
      assign hi_s[gi]   = x[gi+4] ^ y[gi+4] ^ hi_c[gi];
      assign hi_c[gi+1] = (x[gi+4] & y[gi+4]) | (hi_c[gi] & (x[gi+4] ^ y[gi+4]));
    end
  endgenerate

  assign hi_raw       = {hi_c[4], hi_s};
  assign inc_chain[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bec_chain
      assign inc_chain[gi+1] = inc_chain[gi] & hi_raw[gi];
    end
    for (genvar gi = 0; gi < 5; gi++) begin : g_bec_bit
      assign hi_inc[gi] = hi_raw[gi] ^ inc_chain[gi];
    end
  endgenerate

  assign s[3:0]       = lo_s;
  assign {co, s[7:4]} = lo_c[4] ? hi_inc : hi_raw;

endmodule

module serial_csla_add32 #(
  parameter int SLICES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*SLICES-1:0] a,
  input  logic [8*SLICES-1:0] b,
  input  logic                cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*SLICES-1:0] sum,
  output logic                cout
);

  localparam int W     = 8 * SLICES;
  localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg;
  logic             cout_reg;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub_reg;
`endif

  logic       accept;
  logic       last_byte;
  logic [7:0] byte_a;
  logic [7:0] byte_b;
  logic [7:0] slice_sum;
  logic       slice_cout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (last_byte) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs depend on the state register only, never on in_valid/out_ready.
  assign in_ready  = rst_n && (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign accept    = (state_reg == IDLE) && in_valid;
  assign last_byte = (state_reg == BUSY) && (idx_reg == LAST_IDX);

  assign byte_a = a_reg[8*idx_reg +: 8];
`ifdef SERIAL_ADD_SUB_EN
  assign byte_b = sub_reg ? ~b_reg[8*idx_reg +: 8] : b_reg[8*idx_reg +: 8];
`else
  assign byte_b = b_reg[8*idx_reg +: 8];
`endif

  csla_bec_slice8 u_slice (
    .x  (byte_a),
    .y  (byte_b),
    .ci (carry_reg),
    .s  (slice_sum),
    .co (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_reg   <= 1'b0;
`endif
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      idx_reg <= '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_reg   <= sub;
      carry_reg <= sub ? 1'b1 : cin;
`else
      carry_reg <= cin;
`endif
    end else if (state_reg == BUSY) begin
      sum_reg[8*idx_reg +: 8] <= slice_sum;
      carry_reg               <= slice_cout;
      if (last_byte) begin
        cout_reg <= slice_cout;
        idx_reg  <= '0;
      end else begin
        idx_reg <= idx_reg + IDX_W'(1);
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: doc/serial_csla_add32.md
# serial_csla_add32

Byte-serial multi-word adder that time-multiplexes one 8-bit carry-select (BEC) adder slice to add two 32-bit operands over 4 cycles. It sits directly upstream of the Karatsuba partial-product recombination path. The block trades throughput for area: one 8-bit slice replaces a full 32-bit CSLA, and a registered carry links successive bytes. A valid/ready handshake is used on both the input and output sides.

## Interface
Parameters:
- SLICES, default 4: number of 8-bit slices processed. Operand width is 8*SLICES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands and cin are valid.
- in_ready  output  1  block can accept a new operation.
- a  input  8*SLICES  augend.
- b  input  8*SLICES  addend.
- cin  input  1  carry-in to byte 0.
- sub  input  1  subtract select. Present only with SERIAL_ADD_SUB_EN.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  downstream consumes the result.
- sum  output  8*SLICES  result.
- cout  output  1  carry-out of the top byte.

## Operation
- One clock; reset is synchronous and active-low.
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: byte counter idx runs 0..SLICES-1.
  - DONE: out_valid=1.
- IDLE→BUSY on in_valid && in_ready:
  - latch a and b into operand registers;
  - carry register = cin;
  - idx = 0.
- Each BUSY cycle:
  - the 8-bit slice computes a_r[8*idx+:8] + b_r[8*idx+:8] + carry;
  - the result byte is written to sum_r[8*idx+:8];
  - the slice carry-out is written to the carry register;
  - idx increments.
- BUSY→DONE after the idx=SLICES-1 cycle. cout = carry-out of that final byte.
- DONE→IDLE on out_ready. sum and cout hold their values until the next result overwrites them.
- Inputs are ignored outside the IDLE state. a and b may change freely after acceptance.
- No overlap: a new operation is not accepted in the same cycle that a result is consumed.
- Arithmetic is modulo 2^(8*SLICES). cout is the true carry-out (33rd bit for the default width).

## Timing
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, idx=0, carry=0;
  - sum=0, cout=0, out_valid=0;
  - in_ready=0 while rst_n is low, and 1 in the first cycle after release.
- Reset mid-operation: the operation is abandoned and the outputs return to reset values at that edge. No partial result is emitted.
- Latency: accept at edge T0 → out_valid high after edge T(SLICES). This is 4 cycles for the default width.
- Throughput: at most one operation per SLICES+2 cycles when out_ready is held high.
- Back-pressure: with out_ready=0 the block stays in DONE indefinitely. out_valid, sum and cout remain stable and in_ready stays 0.
- in_ready is a function of the state register only (and rst_n). It has no combinational path from in_valid or out_ready.
- Intermediate bytes of sum are visible during BUSY but are only valid when out_valid=1.

## Configuration
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - the sub port exists and is latched at accept;
  - when sub=1, b is inverted byte-wise and the initial carry is forced to 1 (cin ignored), giving a − b;
  - cout=1 means no borrow;
  - sub=0 behaves exactly as the undefined build.
- Undefined:
  - no sub port; the block performs addition only;
  - logic, latency and reset values are otherwise identical.

## Test plan
- Carry across all bytes: a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, out_valid exactly 4 cycles after accept.
- Mixed operands with carry-in: a=0x12345678, b=0x9ABCDEF0, cin=1 → sum=0xACF13569, cout=0.
- Single byte boundary: a=0x000000FF, b=0x00000001, cin=0 → sum=0x00000100, cout=0.
- Back-pressure:
  - drive out_ready=0 for 3 cycles in DONE → sum, cout and out_valid stable and in_ready=0;
  - out_ready=1 → IDLE next cycle and in_ready=1;
  - in_valid held high throughout is accepted only once per operation.
- Reset mid-operation: pull rst_n low at idx=2 → the next edge gives sum=0, cout=0, out_valid=0; after release a fresh operation a=0x01, b=0x56 gives sum=0x00000057.
- SERIAL_ADD_SUB_EN build:
  - a=0x00000005, b=0x00000007, sub=1 → sum=0xFFFFFFFE, cout=0;
  - a=7, b=5, sub=1 → sum=0x00000002, cout=1.
